// File: rtl/sha_mem_pkg.sv
// Shared constants and types for the SHA engine memory arbiter.
package sha_mem_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int AW_DEF      = 16;
  localparam int DW_DEF      = 32;

  // ARB: per-cycle round-robin; LOCKED: grants restricted to the burst owner.
  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: first asserted req at or after ptr, wrapping.
// Purely combinational; returns one-hot winner and its index.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [PW-1:0]      idx
);

  // Walk the ring from ptr and take the first requester found.
  always_comb begin
    int   j;
    logic found;
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        winner[j] = 1'b1;
        idx       = PW'(j);
      end
    end
  end

endmodule

// File: rtl/sha_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory among hash engines.
// Optional burst locking is built when macro SHA_ARB_LOCK_EN is defined;
// without it the lock inputs are ignored and arbitration is per cycle.
module sha_mem_arbiter
  import sha_mem_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         lock,
  input  logic [NUM_REQ-1:0]         we,
  input  logic [NUM_REQ-1:0][AW-1:0] addr,
  input  logic [NUM_REQ-1:0][DW-1:0] wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         rvalid,
  output logic [DW-1:0]              rdata,
  output logic                       mem_clk,
  output logic                       mem_we,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_write_data,
  input  logic [DW-1:0]              mem_read_data
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      ptr;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [PW-1:0]      pick_idx;
  logic [PW-1:0]      gnt_idx;
  logic [NUM_REQ-1:0] rd_vld_p1;

`ifdef SHA_ARB_LOCK_EN
  arb_state_t    state;
  logic [PW-1:0] owner;
`else
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  assign mem_clk = clk;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_onehot),
    .idx    (pick_idx)
  );

  // Grant selection: owner-only while locked, rotating search otherwise.
  always_comb begin
    gnt     = '0;
    gnt_idx = pick_idx;
    if (!reset) begin
`ifdef SHA_ARB_LOCK_EN
      if (state == LOCKED) begin
        gnt_idx = owner;
        if (req[owner]) gnt[owner] = 1'b1;
      end else begin
        gnt = pick_onehot;
      end
`else
      gnt = pick_onehot;
`endif
    end
  end

  // Route the granted requester onto the memory port; zeros when idle.
  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        mem_we         = mem_we | we[i];
        mem_addr       = mem_addr | addr[i];
        mem_write_data = mem_write_data | wdata[i];
      end
    end
  end

  // Advance the round-robin pointer past whoever was just granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

`ifdef SHA_ARB_LOCK_EN
  // Burst lock FSM: enter on a locked grant, leave when the owner drops lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB;
      owner <= '0;
    end else begin
      case (state)
        ARB: begin
          if ((|gnt) && lock[gnt_idx]) begin
            state <= LOCKED;
            owner <= gnt_idx;
          end
        end
        LOCKED: begin
          if (!lock[owner]) state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end
`endif

  // Stage p0 -> p1: memory returns data one cycle after the address.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_p1 <= '0;
    end else begin
      rd_vld_p1 <= gnt & ~we;
    end
  end

  assign rvalid = rd_vld_p1;
  assign rdata  = mem_read_data;

endmodule

// File: doc/sha_mem_arbiter.md
SHA_MEM_ARBITER -- requirements
Module: sha_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of hash-engine requesters, 2..16.
REQ-002 SHALL have parameter AW, default 16: memory address width.
REQ-003 SHALL have parameter DW, default 32: memory data width.
REQ-004 Clocking and reset SHALL be one clock with a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port req, input, NUM_REQ: per-requester access request.
REQ-008 SHALL have port lock, input, NUM_REQ: per-requester burst hold request.
REQ-009 SHALL have port we, input, NUM_REQ: per-requester write enable.
REQ-010 SHALL have port addr, input, NUM_REQ x AW: per-requester address.
REQ-011 SHALL have port wdata, input, NUM_REQ x DW: per-requester write data.
REQ-012 SHALL have port gnt, output, NUM_REQ: one-hot grant, same cycle as the winning req.
REQ-013 SHALL have port rvalid, output, NUM_REQ: one-hot read-data-valid flag.
REQ-014 SHALL have port rdata, output, DW: read data, broadcast to all requesters.
REQ-015 SHALL have port mem_clk, output, 1: equal to clk.
REQ-016 SHALL have port mem_we, output, 1: memory write enable.
REQ-017 SHALL have port mem_addr, output, AW: memory address.
REQ-018 SHALL have port mem_write_data, output, DW: memory write data.
REQ-019 SHALL have port mem_read_data, input, DW: memory read data, valid one cycle after the address.

Function
REQ-020 gnt SHALL be combinational from req, state and pointer; at most one bit high; never high without the matching req.
REQ-021 In the cycle gnt[i]=1: mem_addr=addr[i], mem_we=we[i], mem_write_data=wdata[i]; with no grant, all three SHALL be 0.
REQ-022 Read latency SHALL be 1: a granted read (we[i]=0) in cycle N gives rvalid[i]=1 in N+1, with rdata=mem_read_data; writes never raise rvalid.
REQ-023 State ARB: round-robin search starting at pointer ptr, then ptr+1, and so on, wrapping NUM_REQ-1 to 0.
REQ-024 After any grant to i, ptr SHALL become (i+1) mod NUM_REQ; ptr holds in cycles with no grant.
REQ-025 ARB->LOCKED when the granted i has lock[i]=1; owner register is set to i.
REQ-026 LOCKED: only the owner may be granted (if req[owner]); all others SHALL see gnt=0.
REQ-027 LOCKED->ARB at the edge where lock[owner]=0; that cycle's grant still follows LOCKED rules.
REQ-028 Back-to-back grants to different requesters on consecutive cycles SHALL be allowed; rvalid SHALL track each one independently.
REQ-029 A requester deasserting req while granted SHALL lose the grant that same cycle, with no further side effects.

Reset
REQ-030 When reset is high at an edge: state=ARB, ptr=0, owner=0, rvalid=0.
REQ-031 While reset is high, gnt=0 and mem_we=0.
REQ-032 Reset mid-burst or with a read outstanding SHALL drop the lock and the pending rvalid; no rvalid SHALL follow reset.

Configuration
REQ-033 Macro SHA_ARB_LOCK_EN defined: lock, LOCKED state and owner register SHALL be implemented per REQ-025..027.
REQ-034 SHA_ARB_LOCK_EN undefined: lock SHALL be ignored and the state machine SHALL be pure ARB (per-cycle round-robin).

Structure
REQ-035 Package sha_mem_pkg SHALL hold the default NUM_REQ/AW/DW constants and the arbiter state enum typedef (ARB, LOCKED).
REQ-036 The rotating-priority pick SHALL be sub-module rr_priority_pick: inputs req vector and ptr; outputs one-hot winner and index; purely combinational.

Verification
REQ-037 Reset, then req=4'b1111, all reads -> gnt sequence 0001,0010,0100,1000,0001; rvalid echoes gnt one cycle later.
REQ-038 Write test: req[2]=1, we[2]=1, addr=16'h0040, wdata=32'hDEADBEEF -> same cycle mem_we=1, mem_addr=16'h0040, mem_write_data=32'hDEADBEEF; rvalid stays 0.
REQ-039 Read test: memory model returns 32'h12345678 for 16'h0010; req[1] read -> next cycle rvalid=4'b0010, rdata=32'h12345678.
REQ-040 Lock test (SHA_ARB_LOCK_EN): req[0] with lock[0]=1 for 18 cycles while req[3]=1 -> gnt[0] held all 18 cycles; gnt[3] in the cycle after lock[0] drops.
REQ-041 Reset test: assert reset during a locked burst with a read outstanding -> next cycle rvalid=0 and state ARB; with req=4'b1000, gnt=4'b1000 (search from ptr=0).
REQ-042 Wrap test: ptr=3, req=4'b1001 -> gnt=4'b1000, then gnt=4'b0001.
